// File: rtl/letc_core_stage_buf.sv
// rtl/letc_core_stage_buf.sv - valid/ready pipeline stage buffer with optional skid entry
module letc_core_stage_buf #(
  parameter int DATA_W  = 32,
  parameter bit SKID_EN = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_flush,
  input  logic              i_up_valid,
  output logic              o_up_ready,
  input  logic [DATA_W-1:0] i_up_data,
  output logic              o_dn_valid,
  input  logic              i_dn_ready,
  output logic [DATA_W-1:0] o_dn_data,
  output logic [1:0]        o_count
);

  logic              r_main_valid;
  logic              r_skid_valid;
  logic [DATA_W-1:0] r_main_data;
  logic [DATA_W-1:0] r_skid_data;

  logic w_up_fire;
  logic w_dn_fire;
  logic w_main_from_skid;
  logic w_main_load;
  logic w_skid_load;

  // With a skid entry, ready is a pure register decode so no ready path crosses stages.
  generate
    if (SKID_EN) begin : g_skid
      assign o_up_ready = !r_skid_valid;
    end else begin : g_noskid
      assign o_up_ready = !r_main_valid | i_dn_ready;
    end
  endgenerate

  assign w_up_fire        = i_up_valid & o_up_ready;
  assign w_dn_fire        = r_main_valid & i_dn_ready;
  assign w_main_from_skid = w_dn_fire & r_skid_valid;
  assign w_main_load      = w_up_fire & (!r_main_valid | w_dn_fire) & !r_skid_valid;
  assign w_skid_load      = SKID_EN & w_up_fire & r_main_valid & !w_dn_fire;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_main_data  <= '0;
      r_skid_data  <= '0;
    end else if (i_flush) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else begin
      r_main_valid <= w_main_from_skid | w_main_load | (r_main_valid & !w_dn_fire);
      r_skid_valid <= w_skid_load | (r_skid_valid & !w_dn_fire);
      if (w_main_from_skid) begin
        r_main_data <= r_skid_data;
      end else if (w_main_load) begin
        r_main_data <= i_up_data;
      end
      if (w_skid_load) begin
        r_skid_data <= i_up_data;
      end
    end
  end

  assign o_dn_valid = r_main_valid;
  assign o_dn_data  = r_main_data;
  assign o_count    = {r_skid_valid, r_main_valid & !r_skid_valid};

endmodule

// File: doc/letc_core_stage_buf.md
# letc_core_stage_buf

Parametrised pipeline stage buffer for the 7-stage LETC Core (F1, F2, D, E, M1, M2, W). It carries one opaque packed stage payload (e.g. `d_to_e_s`, `e_to_m1_s`) across a stage boundary using a valid/ready handshake and a synchronous flush. An optional skid entry gives a registered upstream ready, which breaks the combinational ready path across stages. One instance sits at each stage boundary; `DATA_W` is set to `$bits()` of that boundary's struct.

## Interface
- `DATA_W`, default 32: payload width in bits; must be ≥ 1.
- `SKID_EN`, default 1:
  - 1: two entries (main + skid); `o_up_ready` is registered.
  - 0: single entry; `o_up_ready` is combinational from `i_dn_ready`.
- `i_clk`  in  1  core clock; all state updates on the rising edge.
- `i_rst_n`  in  1  reset, asynchronous, active-low.
- `i_flush`  in  1  synchronous flush; discards all held entries.
- `i_up_valid`  in  1  upstream stage presents a payload.
- `o_up_ready`  out  1  buffer will accept a payload this cycle.
- `i_up_data`  in  DATA_W  upstream payload.
- `o_dn_valid`  out  1  main entry holds a payload.
- `i_dn_ready`  in  1  downstream stage consumes the payload this cycle.
- `o_dn_data`  out  DATA_W  main entry payload.
- `o_count`  out  2  entries held: 0, 1 or 2 (2 only when SKID_EN=1).

## Operation
Handshake terms:
- up fire = `i_up_valid & o_up_ready`.
- dn fire = `o_dn_valid & i_dn_ready`.
- `o_dn_data` is always the oldest entry (main). Order is strictly FIFO; no payload is ever duplicated or dropped except by flush.

Ready, per mode:
- SKID_EN=1: `o_up_ready = (count != 2)`. This is purely a register decode; `i_dn_ready` must not appear in its cone.
- SKID_EN=0: `o_up_ready = !main_valid | i_dn_ready`.

State transitions (state = `o_count`):
- EMPTY(0):
  - up fire → ONE; main ← up data.
- ONE(1):
  - up fire & dn fire → ONE; main ← up data.
  - up fire only:
    - SKID_EN=1 → FULL; skid ← up data.
    - SKID_EN=0 cannot occur, because ready is then 0.
  - dn fire only → EMPTY.
  - neither → hold.
- FULL(2), SKID_EN=1 only:
  - up ready is 0.
  - dn fire → ONE; main ← skid.
  - otherwise hold.

Flush:
- `i_flush=1` forces EMPTY at the next edge, regardless of any up fire or dn fire in the same cycle.
- A payload presented in a flush cycle is discarded.
- Flush has no other effect on the outputs during its own cycle; ready and valid follow normal rules.

Data registers:
- Main and skid data load only on their load conditions above.
- Contents while invalid are don't-care for function, but they are reset to 0 for determinism.

## Timing
- Reset (`i_rst_n`=0, asynchronous):
  - `o_dn_valid`=0, `o_count`=0, `o_dn_data`=0, skid data = 0.
  - `o_up_ready`=1 in both modes.
- Release of reset is synchronised externally; the buffer accepts on the first edge after release.
- Latency: payload accepted at edge N appears on `o_dn_data` with `o_dn_valid`=1 after edge N, i.e. in cycle N+1.
- Throughput is 1 payload/cycle with `i_dn_ready` held high, in both modes.
- SKID_EN=1 backpressure:
  - `i_dn_ready` drops while count is 1 and upstream still fires → count 2 after that edge.
  - `o_up_ready` drops in the following cycle, with no loss.
- Asynchronous reset mid-transfer discards all entries immediately; outputs go to their reset values without waiting for a clock.
- Simultaneous flush + up fire + dn fire: the downstream consumes the current main payload this cycle. Result is EMPTY, count 0.

## Test plan
- Reset then stream: send 0x11, 0x22, 0x33 on consecutive cycles with `i_dn_ready`=1 → received in order, 1-cycle latency, `o_count` constant 1 while streaming, `o_up_ready` never 0.
- Skid fill (SKID_EN=1): accept 0xA0, 0xA1 with `i_dn_ready`=0 → `o_count`=2, `o_up_ready`=0 the next cycle; raise `i_dn_ready` → 0xA0 then 0xA1 delivered, count 2→1→0.
- No-skid backpressure (SKID_EN=0): main holds 0x5, `i_dn_ready`=0 → `o_up_ready`=0 combinationally. Raise `i_dn_ready` with 0x6 valid → 0x5 consumed and 0x6 loaded on the same edge.
- Flush: count=2 (0x1, 0x2), assert `i_flush` with `i_up_valid`=1 (0x3) and `i_dn_ready`=1 → next cycle count=0, `o_dn_valid`=0, 0x3 never appears downstream.
- Async reset mid-operation: count=2, drop `i_rst_n` between clock edges → `o_dn_valid`=0 and `o_count`=0 immediately, before the next edge.
- Random valid/ready over 10k cycles, DATA_W=7 and DATA_W=300, both modes → scoreboard shows exact FIFO order and no loss. With SKID_EN=1, an assertion confirms `o_up_ready` has no combinational dependence on `i_dn_ready`.
